tdm_demux8: RTL and testbench

//  Serial-to-parallel TDM demultiplexer: the receive end of an 8-slot time-multiplexed line.

---
 rtl/tdm_pkg.sv | 24 ++
 rtl/tdm_demux8_decoder.sv | 23 ++
 rtl/tdm_demux8.sv | 140 ++++++++++++++
 tb/tb_tdm_demux8.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-lane TDM demultiplexer.
// Define TDM_PARITY_EN to append an even-parity slot to every frame.
package tdm_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int LANES = 8;

`ifdef TDM_PARITY_EN
  localparam int FRAME_LEN = 9;
  localparam int SLOT_W    = 4;
`else
  localparam int FRAME_LEN = 8;
  localparam int SLOT_W    = 3;
`endif

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tdm_demux8_decoder.sv
// Gate-level 3-to-8 one-hot decoder used as the lane capture enable.
module decoder3to8 (
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);

  logic [2:0] in_n;

  not u_n0 (in_n[0], in[0]);
  not u_n1 (in_n[1], in[1]);
  not u_n2 (in_n[2], in[2]);

  and u_a0 (out[0], en, in_n[2], in_n[1], in_n[0]);
  and u_a1 (out[1], en, in_n[2], in_n[1], in[0]);
  and u_a2 (out[2], en, in_n[2], in[1],   in_n[0]);
  and u_a3 (out[3], en, in_n[2], in[1],   in[0]);
  and u_a4 (out[4], en, in[2],   in_n[1], in_n[0]);
  and u_a5 (out[5], en, in[2],   in_n[1], in[0]);
  and u_a6 (out[6], en, in[2],   in[1],   in_n[0]);
  and u_a7 (out[7], en, in[2],   in[1],   in[0]);

endmodule

// File: rtl/tdm_demux8.sv
// Receive end of an 8-slot TDM line: aligns on sync, routes slot k to dout[k].
// Optional TDM_PARITY_EN adds a ninth, even-parity slot checked before release.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sync,
  output logic [7:0]        dout,
  output logic              dout_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_err
);

  localparam logic [7:0]        TIMEOUT_C = TIMEOUT[7:0];
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  state_e            state_r, state_n;
  logic [SLOT_W-1:0] slot_r, slot_n;
  logic [7:0]        cnt_r, cnt_n, cnt_inc_s;
  logic [7:0]        shadow_r, shadow_cap_s;
  logic [7:0]        dout_r, dout_n;
  logic              dv_r, dv_n, fe_r, fe_n;
  logic              start_s, cap_s;
  logic [2:0]        dec_sel_s;
  logic [7:0]        lane_en_s;

  // Lane select: a sync bit always lands in lane 0, otherwise the current slot.
  always_comb begin
    start_s   = din_valid & sync;
`ifdef TDM_PARITY_EN
    cap_s     = start_s | (din_valid & (state_r == ST_RUN) & ~slot_r[3]);
`else
    cap_s     = start_s | (din_valid & (state_r == ST_RUN));
`endif
    dec_sel_s = start_s ? 3'd0 : slot_r[2:0];
    cnt_inc_s = cnt_r + 8'd1;
  end

  decoder3to8 u_dec (
    .in  (dec_sel_s),
    .en  (cap_s),
    .out (lane_en_s)
  );

  assign shadow_cap_s = (shadow_r & ~lane_en_s) | ({8{din}} & lane_en_s);

  // Next-state, slot/timeout counters and output pulses.
  always_comb begin
    state_n = state_r;
    slot_n  = slot_r;
    cnt_n   = cnt_r;
    dout_n  = dout_r;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    case (state_r)
      ST_HUNT: begin
        cnt_n = 8'd0;
        if (din_valid & sync) begin
          state_n = ST_RUN;
          slot_n  = SLOT_ONE;
        end else if (din_valid) begin
          fe_n = 1'b1;
        end else begin
          state_n = ST_HUNT;
        end
      end
      ST_RUN: begin
        if (din_valid) begin
          cnt_n = 8'd0;
          if (sync) begin
            // Misplaced sync restarts the frame from this bit.
            fe_n   = (slot_r != {SLOT_W{1'b0}});
            slot_n = SLOT_ONE;
          end else if (slot_r == LAST_SLOT) begin
            state_n = ST_HUNT;
            slot_n  = {SLOT_W{1'b0}};
`ifdef TDM_PARITY_EN
            if (din == even_parity(shadow_r)) begin
              dout_n = shadow_r;
              dv_n   = 1'b1;
            end else begin
              fe_n = 1'b1;
            end
`else
            dout_n = shadow_cap_s;
            dv_n   = 1'b1;
`endif
          end else begin
            slot_n = slot_r + SLOT_ONE;
          end
        end else if (cnt_inc_s == TIMEOUT_C) begin
          fe_n    = 1'b1;
          state_n = ST_HUNT;
          slot_n  = {SLOT_W{1'b0}};
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_inc_s;
        end
      end
      default: begin
        state_n = ST_HUNT;
        slot_n  = {SLOT_W{1'b0}};
        cnt_n   = 8'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_HUNT;
      slot_r   <= {SLOT_W{1'b0}};
      cnt_r    <= 8'd0;
      shadow_r <= 8'h00;
      dout_r   <= 8'h00;
      dv_r     <= 1'b0;
      fe_r     <= 1'b0;
    end else begin
      state_r  <= state_n;
      slot_r   <= slot_n;
      cnt_r    <= cnt_n;
      shadow_r <= shadow_cap_s;
      dout_r   <= dout_n;
      dv_r     <= dv_n;
      fe_r     <= fe_n;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dv_r;
  assign slot       = slot_r;
  assign frame_err  = fe_r;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8; expected values are hand-derived frame constants.
module tb_tdm_demux8;

  localparam int FL = tdm_pkg::FRAME_LEN;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      din = 1'b0;
  logic                      din_valid = 1'b0;
  logic                      sync = 1'b0;
  logic [7:0]                dout;
  logic                      dout_valid;
  logic [tdm_pkg::SLOT_W-1:0] slot;
  logic                      frame_err;

  int tests = 0;
  int fails = 0;

  tdm_demux8 #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read 1ns after the rising edge.
  task automatic drive(input logic v, input logic s, input logic d);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic fbit(input logic [7:0] f, input int k, input logic flip);
    if (k < 8) return f[k];
    else return (^f) ^ flip;
  endfunction

  task automatic send_from(input logic [7:0] f, input int k0, input int gap, input logic flip);
    for (int k = k0; k < FL; k++) begin
      drive(1'b1, (k == 0), fbit(f, k, flip));
      if (k < FL - 1 && gap > 0) begin
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0);
        chk("gap_slot", 32'(slot), 32'(k + 1));
        chk("gap_err", 32'(frame_err), 32'd0);
      end
    end
  endtask

  task automatic send_part(input logic [7:0] f, input int n);
    for (int k = 0; k < n; k++) drive(1'b1, (k == 0), f[k]);
  endtask

  task automatic chk_done(input string tag, input logic [7:0] f);
    chk({tag, "_dout"}, 32'(dout), 32'(f));
    chk({tag, "_dv"}, 32'(dout_valid), 32'd1);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_slot"}, 32'(slot), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    chk({tag, "_dv_pulse"}, 32'(dout_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_dv", 32'(dout_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back frame 0x4D
    send_from(8'h4D, 0, 0, 1'b0);
    chk_done("t1", 8'h4D);

    // Stray bit in HUNT, then an all-ones frame
    drive(1'b1, 1'b0, 1'b1);
    chk("t3_err", 32'(frame_err), 32'd1);
    chk("t3_dv", 32'(dout_valid), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t3_err_pulse", 32'(frame_err), 32'd0);
    send_from(8'hFF, 0, 0, 1'b0);
    chk_done("t3", 8'hFF);

    // 0x4D with 3-cycle stalls between slots
    send_from(8'h4D, 0, 3, 1'b0);
    chk_done("t2", 8'h4D);

    // Sync re-asserted at slot 4 starts a new 0xA5 frame
    send_part(8'h4D, 4);
    chk("t4_slot4", 32'(slot), 32'd4);
    drive(1'b1, 1'b1, 1'b1);
    chk("t4_err", 32'(frame_err), 32'd1);
    chk("t4_dout_held", 32'(dout), 32'h4D);
    chk("t4_slot1", 32'(slot), 32'd1);
    send_from(8'hA5, 1, 0, 1'b0);
    chk_done("t4", 8'hA5);

    // Timeout after slot 2
    send_part(8'h3C, 3);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b0);
    chk("t5_no_err_15", 32'(frame_err), 32'd0);
    chk("t5_slot_held", 32'(slot), 32'd3);
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_err", 32'(frame_err), 32'd1);
    chk("t5_slot0", 32'(slot), 32'd0);
    chk("t5_dout", 32'(dout), 32'hA5);
    drive(1'b0, 1'b0, 1'b0);
    chk("t5_err_pulse", 32'(frame_err), 32'd0);
    drive(1'b1, 1'b0, 1'b1);
    chk("t5_hunt", 32'(frame_err), 32'd1);

    // Asynchronous reset at slot 5
    send_part(8'h4D, 5);
    chk("t6_slot5", 32'(slot), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_dout", 32'(dout), 32'h00);
    chk("t6_slot", 32'(slot), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_dv", 32'(dout_valid), 32'd0);
    chk("t6_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

`ifdef TDM_PARITY_EN
    send_from(8'h4D, 0, 0, 1'b0);
    chk_done("par_ok", 8'h4D);
    send_from(8'hFF, 0, 0, 1'b1);
    chk("par_bad_err", 32'(frame_err), 32'd1);
    chk("par_bad_dv", 32'(dout_valid), 32'd0);
    chk("par_bad_dout", 32'(dout), 32'h4D);
    chk("par_bad_slot", 32'(slot), 32'd0);
`else
    send_from(8'h96, 0, 0, 1'b0);
    chk_done("t6_after", 8'h96);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
